// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage; stalls IF..EX while busy.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |b| >= |a|.
module ex_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src_a,
  input  logic [WIDTH-1:0] div_src_b,
  input  logic             div_cancel,
  output logic             stallreq_for_ex,
  output logic             div_valid,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo
);

  localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;

  // Operand conditioning, only meaningful while IDLE
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic             kill;

  assign a_neg  = div_signed & div_src_a[WIDTH-1];
  assign b_neg  = div_signed & div_src_b[WIDTH-1];
  assign abs_a  = a_neg ? (WIDTH'(0) - div_src_a) : div_src_a;
  assign abs_b  = b_neg ? (WIDTH'(0) - div_src_b) : div_src_b;
  assign b_zero = (div_src_b == '0);
  assign kill   = div_cancel | ~div_start;

`ifdef DIV_EARLY_OUT_EN
  logic abs_eq;
  logic early_hit;
  assign abs_eq    = (abs_a == abs_b);
  assign early_hit = (abs_b >= abs_a);
`endif

  // One restoring shift-subtract step; rem < divisor keeps trial within WIDTH+1 bits
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = trial - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_step = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], q_bit};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; cancel or a vanished instruction always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (div_start && !div_cancel) begin
          if (b_zero) state_nxt = S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
          else if (early_hit) state_nxt = S_END;
`endif
          else state_nxt = S_ON;
        end
      end
      S_DIVZERO: state_nxt = kill ? S_IDLE : S_END;
      S_ON: begin
        if (kill)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode: datapath enables and the unsigned result about to be published
  logic             load_op;
  logic             step_en;
  logic             res_load;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             res_sq;
  logic             res_sr;

  always_comb begin
    load_op  = 1'b0;
    step_en  = 1'b0;
    res_load = (state_nxt == S_END);
    res_q    = quo_step;
    res_r    = rem_step;
    res_sq   = sign_q;
    res_sr   = sign_r;
    unique case (state)
      S_IDLE: begin
        load_op = (state_nxt == S_ON);
`ifdef DIV_EARLY_OUT_EN
        res_q   = abs_eq ? WIDTH'(1) : '0;
        res_r   = abs_eq ? '0 : abs_a;
        res_sq  = a_neg ^ b_neg;
        res_sr  = a_neg;
`endif
      end
      S_DIVZERO: begin
        res_q = '0;
        res_r = '0;
      end
      S_ON:    step_en = (state_nxt != S_IDLE);
      default: ;
    endcase
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
    end else if (load_op) begin
      cnt     <= '0;
      quo     <= abs_a;
      rem     <= '0;
      divisor <= abs_b;
      sign_q  <= a_neg ^ b_neg;
      sign_r  <= a_neg;
    end else if (step_en) begin
      cnt     <= cnt + CW'(1);
      quo     <= quo_step;
      rem     <= rem_step;
    end
  end

  // Result registers: written only on entry to END, held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_valid <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else begin
      div_valid <= res_load;
      if (res_load) begin
        div_lo <= res_sq ? (WIDTH'(0) - res_q) : res_q;
        div_hi <= res_sr ? (WIDTH'(0) - res_r) : res_r;
      end
    end
  end

  // Combinational stall request; drops in END so EX advances with the result
  assign stallreq_for_ex = resetn & div_start & (state != S_END);

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed cases plus random divides against an arithmetic model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_ex_div_unit;

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_src_a;
  logic [31:0] div_src_b;
  logic        div_cancel;
  logic        stallreq_for_ex;
  logic        div_valid;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  int n_cmp = 0;
  int n_err = 0;

  ex_div_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .div_src_a       (div_src_a),
    .div_src_b       (div_src_b),
    .div_cancel      (div_cancel),
    .stallreq_for_ex (stallreq_for_ex),
    .div_valid       (div_valid),
    .div_hi          (div_hi),
    .div_lo          (div_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, in 64-bit arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sb, ma, mb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; lat = 2;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (mb >= ma) lat = 1;
`endif
    end
  endfunction

  // Starts at a negedge with DUT idle; returns at the negedge after the valid cycle, start low
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    logic [31:0] eq, er;
    int          elat;
    int          got;
    bit          stall_bad;
    model(a, b, s, eq, er, elat);
    div_src_a  = a;
    div_src_b  = b;
    div_signed = s;
    div_start  = 1'b1;
    #1;
    chk({tag, "_stall0"}, 32'(stallreq_for_ex), 32'd1);
    got = -1;
    stall_bad = 1'b0;
    for (int k = 1; k <= 40 && got < 0; k++) begin
      @(negedge clk);
      if (div_valid) got = k;
      else if (!stallreq_for_ex) stall_bad = 1'b1;
      if (k == 5) begin
        div_src_a = $urandom;
        div_src_b = $urandom;
      end
    end
    chk({tag, "_lat"}, 32'(got), 32'(elat));
    chk({tag, "_stallbusy"}, 32'(stall_bad), 32'd0);
    if (got > 0) begin
      chk({tag, "_lo"}, div_lo, eq);
      chk({tag, "_hi"}, div_hi, er);
      chk({tag, "_stallend"}, 32'(stallreq_for_ex), 32'd0);
    end
    div_start = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(div_valid), 32'd0);
    chk({tag, "_hold"}, div_lo, eq);
  endtask

  // Idle window in which no result may appear
  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (div_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_src_a  = '0;
    div_src_b  = '0;
    div_cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(div_valid), 32'd0);
    chk("rst_hi", div_hi, 32'd0);
    chk("rst_lo", div_lo, 32'd0);
    chk("rst_stall", 32'(stallreq_for_ex), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("div_5_0", 32'd5, 32'd0, 1'b1);
    run_div("divu_9_3", 32'd9, 32'd3, 1'b0);
    run_div("divu_8_3", 32'd8, 32'd3, 1'b0);
    run_div("divu_3_10", 32'd3, 32'd10, 1'b0);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("div_7_m7", 32'd7, 32'hFFFF_FFF9, 1'b1);
    run_div("divu_big", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Cancel at cycle 10 of a divide; previous result must survive
    run_div("pre_cancel", 32'd100, 32'd7, 1'b0);
    div_src_a = 32'd1000; div_src_b = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    div_cancel = 1'b1;
    div_start  = 1'b0;
    @(negedge clk);
    div_cancel = 1'b0;
    chk("cancel_stall", 32'(stallreq_for_ex), 32'd0);
    chk("cancel_valid", 32'(div_valid), 32'd0);
    expect_quiet("cancel_quiet", 40);
    chk("cancel_hi", div_hi, 32'd2);
    chk("cancel_lo", div_lo, 32'd14);

    // Cancel wins over start in IDLE
    div_src_a = 32'd50; div_src_b = 32'd5; div_start = 1'b1; div_cancel = 1'b1;
    @(negedge clk);
    div_start = 1'b0; div_cancel = 1'b0;
    expect_quiet("cancel_wins", 40);

    // Instruction vanishing mid-divide acts as a cancel
    div_src_a = 32'd77; div_src_b = 32'd3; div_start = 1'b1;
    repeat (6) @(negedge clk);
    div_start = 1'b0;
    expect_quiet("vanish_quiet", 40);
    chk("vanish_lo", div_lo, 32'd14);

    // Asynchronous reset in the middle of a divide
    div_src_a = 32'd1000; div_src_b = 32'd7; div_start = 1'b1;
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_hi", div_hi, 32'd0);
    chk("arst_lo", div_lo, 32'd0);
    chk("arst_valid", 32'(div_valid), 32'd0);
    chk("arst_stall", 32'(stallreq_for_ex), 32'd0);
    @(negedge clk);
    div_start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    run_div("post_rst", 32'd100, 32'd7, 1'b0);

    // Random operands, mixing zero, small, and same-magnitude divisors
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = a;
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_div($sformatf("rnd%0d", i), a, b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
